// File: rtl/ram_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rd_ctrl_pkg
//  Description : Shared types and constants for the spectrum RAM reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_rd_ctrl_pkg;

    // Default bus widths of the spectrum RAM read port.
    localparam int C_ADDR_W  = 12;
    localparam int C_DATA_W  = 16;

    // Single-sided FFT bin count, shared with the RAM writer.
    localparam int C_BIN_CNT = 2048;

    // Reader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rd_ctrl_if
//  Description : Spectrum RAM read-port bundle (address/enable out, data in).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_rd_ctrl_if
    import ram_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Reader side drives address/enable and receives data.
    modport master (output rd_en, output rd_addr, input rd_data);
    // RAM side answers reads.
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/ram_rd_ctrl_peak_top2.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rd_ctrl_peak_top2
//  Description : 3-sample sliding window local-maximum detector that keeps
//                the two strongest peaks (address and magnitude).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_ctrl_peak_top2
    import ram_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] threshold,
    output logic [1:0]        peak_cnt,
    output logic [ADDR_W-1:0] peak1_addr,
    output logic [DATA_W-1:0] peak1_mag,
    output logic [ADDR_W-1:0] peak2_addr,
    output logic [DATA_W-1:0] peak2_mag
);
    // Window: s0 oldest, s1 middle (the candidate), s2 newest.
    logic [DATA_W-1:0] r_s0, r_s1, r_s2;
    logic [ADDR_W-1:0] r_a1, r_a2;
    logic [1:0]        r_fill;      // valid samples in the window, saturates at 3
    logic              r_adv;       // window moved on the previous edge

    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_p1_addr, r_p2_addr;
    logic [DATA_W-1:0] r_p1_mag,  r_p2_mag;

    // Strict rise on the left, non-strict on the right: a plateau is
    // reported once, at its first bin. The edge bins never reach s1 with a
    // full window, so they are never candidates.
    logic w_cand;
    assign w_cand = r_adv && (r_fill == 2'd3) && (r_s1 > r_s0) &&
                    (r_s1 >= r_s2) && (r_s1 >= threshold);

    // Advance the window on returning data and insert candidates into the top-2 list.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s0      <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_fill    <= 2'd0;
            r_adv     <= 1'b0;
            r_cnt     <= 2'd0;
            r_p1_addr <= '0;
            r_p1_mag  <= '0;
            r_p2_addr <= '0;
            r_p2_mag  <= '0;
        end else begin
            r_adv <= in_valid;
            if (in_valid) begin
                r_s0 <= r_s1;
                r_s1 <= r_s2;
                r_s2 <= in_data;
                r_a1 <= r_a2;
                r_a2 <= in_addr;
                if (r_fill != 2'd3) begin
                    r_fill <= r_fill + 2'd1;
                end
            end
            if (w_cand) begin
                // Strict compares keep the earlier (lower) bin on ties.
                if (r_s1 > r_p1_mag) begin
                    r_p2_addr <= r_p1_addr;
                    r_p2_mag  <= r_p1_mag;
                    r_p1_addr <= r_a1;
                    r_p1_mag  <= r_s1;
                end else if ((r_s1 > r_p2_mag) || (r_cnt != 2'd2)) begin
                    r_p2_addr <= r_a1;
                    r_p2_mag  <= r_s1;
                end
                if (r_cnt != 2'd2) begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign peak_cnt   = r_cnt;
    assign peak1_addr = r_p1_addr;
    assign peak1_mag  = r_p1_mag;
    assign peak2_addr = r_p2_addr;
    assign peak2_mag  = r_p2_mag;

endmodule
`default_nettype wire

// File: rtl/ram_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rd_ctrl
//  Description : Spectrum RAM reader. Scans the single-sided modulus bins
//                after capture and reports the two strongest local peaks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_ctrl
    import ram_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W,
    parameter int DATA_W     = C_DATA_W,
    parameter int START_ADDR = 1,
    parameter int SCAN_LEN   = C_BIN_CNT,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_start,
    input  logic [DATA_W-1:0] threshold,
    ram_rd_ctrl_if.master     ram,
    output logic              busy,
    output logic              rd_done,
    output logic [1:0]        peak_cnt,
    output logic [ADDR_W-1:0] peak1_addr,
    output logic [DATA_W-1:0] peak1_mag,
    output logic [ADDR_W-1:0] peak2_addr,
    output logic [DATA_W-1:0] peak2_mag
);
    localparam logic [ADDR_W-1:0] C_FIRST      = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] C_LAST       = ADDR_W'(START_ADDR + SCAN_LEN - 1);
    localparam logic [2:0]        C_DRAIN_LAST = 3'(RD_LAT + 1);

    rd_state_t         r_state;
    logic              r_start_q;
    logic              r_armed;     // rd_start seen low since reset
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [2:0]        r_drain_cnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_thr;

    logic [RD_LAT-1:0] r_vld_pipe;
    logic [ADDR_W-1:0] r_addr_pipe [RD_LAT];

    logic w_start;
    logic w_clear;

    // A rising edge only counts once rd_start has been low after reset, so a
    // level held high across a reset cannot restart the scan.
    assign w_start = rd_start && !r_start_q && r_armed;
    assign w_clear = w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Register rd_start for edge detection and arm after it is seen low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= rd_start;
            if (!rd_start) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Scan control: address generation, drain wait and completion flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_drain_cnt <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_thr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state   <= ST_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= C_FIRST;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_thr     <= threshold;
                    end
                end
                ST_READ: begin
                    if (r_rd_addr == C_LAST) begin
                        r_state     <= ST_DRAIN;
                        r_rd_en     <= 1'b0;
                        r_drain_cnt <= 3'd0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Covers the RAM latency plus one edge for the final
                    // window evaluation to land in the peak registers.
                    if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag returning RAM data with its valid flag and bin address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0]  <= r_rd_en;
            r_addr_pipe[0] <= r_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end
        end
    end

    assign ram.rd_en   = r_rd_en;
    assign ram.rd_addr = r_rd_addr;
    assign busy        = r_busy;
    assign rd_done     = r_done;

    ram_rd_ctrl_peak_top2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_peak_top2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .in_valid   (r_vld_pipe[RD_LAT-1]),
        .in_addr    (r_addr_pipe[RD_LAT-1]),
        .in_data    (ram.rd_data),
        .threshold  (r_thr),
        .peak_cnt   (peak_cnt),
        .peak1_addr (peak1_addr),
        .peak1_mag  (peak1_mag),
        .peak2_addr (peak2_addr),
        .peak2_mag  (peak2_mag)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_rd_ctrl
//  Description : Directed self-checking bench for ram_rd_ctrl, run side by
//                side with RAM read latency 1 and 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rd_ctrl;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] threshold = '0;

    ram_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    ram_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    logic          busy1, done1, busy3, done3;
    logic [1:0]    pc1, pc3;
    logic [AW-1:0] p1a1, p2a1, p1a3, p2a3;
    logic [DW-1:0] p1m1, p2m1, p1m3, p2m3;

    ram_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(1), .SCAN_LEN(2048), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .threshold(threshold), .ram(if1),
        .busy(busy1), .rd_done(done1), .peak_cnt(pc1),
        .peak1_addr(p1a1), .peak1_mag(p1m1), .peak2_addr(p2a1), .peak2_mag(p2m1)
    );

    ram_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(1), .SCAN_LEN(2048), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .threshold(threshold), .ram(if3),
        .busy(busy3), .rd_done(done3), .peak_cnt(pc3),
        .peak1_addr(p1a3), .peak1_mag(p1m3), .peak2_addr(p2a3), .peak2_mag(p2m3)
    );

    always #5 clk = ~clk;

    // Spectrum RAM model shared by both readers, with 1- and 3-cycle read latency.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] q1;
    logic [DW-1:0] q3 [3];

    always @(posedge clk) begin
        q1    <= mem[if1.rd_addr];
        q3[0] <= mem[if3.rd_addr];
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end
    assign if1.rd_data = q1;
    assign if3.rd_data = q3[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fill(input logic [DW-1:0] bg);
        for (int i = 0; i < 4096; i++) mem[i] = bg;
    endtask

    task automatic drop_start();
        @(negedge clk) rd_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raise rd_start, follow one scan on both readers and check its timing.
    task automatic do_scan(input string tag);
        int c1 = 0;
        int c3 = 0;
        @(negedge clk) rd_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) chk({tag, "_addr5"}, 32'(if1.rd_addr), 32'd6);
            if (n == 10) begin
                chk({tag, "_busy_mid"}, 32'(busy1), 32'd1);
                chk({tag, "_done1_mid"}, 32'(done1), 32'd0);
                chk({tag, "_done3_mid"}, 32'(done3), 32'd0);
            end
            if (c1 == 0 && done1) c1 = n;
            if (c3 == 0 && done3) c3 = n;
            if (c1 != 0 && c3 != 0) break;
        end
        chk({tag, "_lat1"}, 32'(c1), 32'd2051);
        chk({tag, "_lat3"}, 32'(c3), 32'd2053);
        chk({tag, "_busy_end"}, 32'(busy1), 32'd0);
        chk({tag, "_addr_last"}, 32'(if1.rd_addr), 32'd2048);
        chk({tag, "_rden_end"}, 32'(if1.rd_en | if3.rd_en), 32'd0);
    endtask

    task automatic check_peaks(input string tag, input logic [31:0] cnt,
                               input logic [31:0] a1, input logic [31:0] m1,
                               input logic [31:0] a2, input logic [31:0] m2);
        chk({tag, "_cnt_L1"},  32'(pc1),  cnt);
        chk({tag, "_p1a_L1"},  32'(p1a1), a1);
        chk({tag, "_p1m_L1"},  32'(p1m1), m1);
        chk({tag, "_p2a_L1"},  32'(p2a1), a2);
        chk({tag, "_p2m_L1"},  32'(p2m1), m2);
        chk({tag, "_cnt_L3"},  32'(pc3),  cnt);
        chk({tag, "_p1a_L3"},  32'(p1a3), a1);
        chk({tag, "_p1m_L3"},  32'(p1m3), m1);
        chk({tag, "_p2a_L3"},  32'(p2a3), a2);
        chk({tag, "_p2m_L3"},  32'(p2m3), m2);
    endtask

    initial begin
        int en_seen;
        bit hit;
        fill('0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_done",  32'(done1), 32'd0);
        chk("rst_busy",  32'(busy1), 32'd0);
        chk("rst_rden",  32'(if1.rd_en), 32'd0);
        chk("rst_addr",  32'(if1.rd_addr), 32'd0);
        check_peaks("rst", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Single tone.
        fill(16'd10);
        mem[100] = 16'd5000;
        threshold = 16'd100;
        do_scan("tone1");
        check_peaks("tone1", 1, 100, 5000, 0, 0);
        drop_start();

        // Two tones.
        fill('0);
        mem[300]  = 16'd800;
        mem[1200] = 16'd3000;
        do_scan("tone2");
        check_peaks("tone2", 2, 1200, 3000, 300, 800);
        drop_start();

        // Three tones, tie on the second place keeps the lower bin.
        fill('0);
        mem[50]   = 16'd900;
        mem[500]  = 16'd3000;
        mem[1500] = 16'd900;
        do_scan("tone3");
        check_peaks("tone3", 2, 500, 3000, 50, 900);
        drop_start();

        // Edge bins and sub-threshold bump.
        fill('0);
        mem[1]    = 16'd9000;
        mem[2048] = 16'd9000;
        mem[700]  = 16'd50;
        do_scan("edges");
        check_peaks("edges", 0, 0, 0, 0, 0);
        chk("edges_done", 32'(done1 & done3), 32'd1);
        drop_start();

        // Plateau reported once at its first bin.
        fill('0);
        mem[400] = 16'd2000;
        mem[401] = 16'd2000;
        mem[402] = 16'd2000;
        do_scan("plat");
        check_peaks("plat", 1, 400, 2000, 0, 0);

        // rd_start held high through DONE must not retrigger.
        en_seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (if1.rd_en || if3.rd_en) en_seen++;
        end
        chk("hold_rden", 32'(en_seen), 32'd0);
        chk("hold_done", 32'(done1), 32'd1);

        // Fresh edge rescans with identical results.
        drop_start();
        do_scan("rescan");
        check_peaks("rescan", 1, 400, 2000, 0, 0);
        drop_start();

        // Reset in the middle of a scan.
        hit = 1'b0;
        @(negedge clk) rd_start = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (if1.rd_addr == 12'd1000) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reach1000", 32'(hit), 32'd1);
        chk("abort_pre_peak", 32'(p1a1), 32'd400);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rden", 32'(if1.rd_en | if3.rd_en), 32'd0);
        chk("abort_addr", 32'(if1.rd_addr), 32'd0);
        chk("abort_busy", 32'(busy1 | busy3), 32'd0);
        chk("abort_done", 32'(done1 | done3), 32'd0);
        check_peaks("abort", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        en_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (if1.rd_en || if3.rd_en || busy1) en_seen++;
        end
        chk("abort_idle", 32'(en_seen), 32'd0);
        drop_start();
        do_scan("after_rst");
        check_peaks("after_rst", 1, 400, 2000, 0, 0);
        drop_start();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_rd_ctrl.md
Name: ram_rd_ctrl

Overview:
Reader side of the spectrum RAM. Starts when the RAM writer signals its capture is complete, and streams the single-sided FFT modulus bins back out of the RAM. Scans those bins for local maxima and reports the two strongest peaks, by bin address and magnitude, to the frequency-separation logic. Sits between the spectrum RAM read port and the frequency-separation/measurement block.

Parameters:
ADDR_W, 12, RAM address width.
DATA_W, 16, modulus data width.
START_ADDR, 1, first bin scanned; bin 0 (DC) is skipped.
SCAN_LEN, 2048, number of bins scanned, i.e. the single-sided bin count; START_ADDR+SCAN_LEN must be ≤ 2^ADDR_W.
RD_LAT, 1, RAM read latency in cycles, from rd_en/rd_addr to valid rd_data; legal range 1..3.

Ports:
clk  in  1  FFT clock.
rst_n  in  1  synchronous, active-low reset.
rd_start  in  1  level input driven by the writer's done flag; a rising edge starts one scan.
threshold  in  DATA_W  minimum magnitude for a peak; sampled at scan start.
rd_data  in  DATA_W  RAM read data.
rd_addr  out  ADDR_W  RAM read address.
rd_en  out  1  RAM read enable.
busy  out  1  high from scan start until rd_done.
rd_done  out  1  scan complete; peak outputs valid.
peak_cnt  out  2  number of valid peaks found (0, 1 or 2).
peak1_addr  out  ADDR_W  bin address of the largest peak.
peak1_mag  out  DATA_W  magnitude of the largest peak.
peak2_addr  out  ADDR_W  bin address of the second-largest peak.
peak2_mag  out  DATA_W  magnitude of the second-largest peak.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: on clk edge with rst_n=0, all outputs and all state go to 0 and the FSM enters IDLE.
- rd_start is registered once. Start condition is rd_start=1 while the registered copy is 0. A level held high never retriggers.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start, go to READ.
  - Clear peaks, peak_cnt and rd_done.
  - Latch threshold.
  - Set rd_addr=START_ADDR.
- READ:
  - rd_en=1 every cycle.
  - rd_addr increments by 1 per cycle through START_ADDR+SCAN_LEN-1.
  - After issuing the last address, go to DRAIN. rd_addr holds its last value.
- DRAIN:
  - rd_en=0.
  - Wait RD_LAT+1 cycles so the last sample returns and the final candidate is evaluated, then go to DONE.
- DONE:
  - rd_done=1 and busy=0.
  - Peak outputs are held stable.
  - A new start edge behaves as in IDLE and rescans.
- Data tracking:
  - A valid shift register of depth RD_LAT tags returning data.
  - A parallel address pipeline tracks the bin address of each returning sample.
- Window: a 3-sample window (s0 oldest, s1 middle, s2 newest) advances on each valid return.
- Candidate rule: s1 is a candidate when the window holds 3 valid samples and s1 > s0, s1 ≥ s2 and s1 ≥ threshold_latched.
  - This rule lets a plateau count once, at its first bin.
- Edge bins: the first and last scanned bins are never candidates because each lacks a neighbour.
- Peak update, same cycle the candidate is detected:
  - If mag > peak1_mag: peak2 takes the old peak1, and peak1 takes the candidate.
  - Else if mag > peak2_mag or peak_cnt < 2: peak2 takes the candidate.
  - peak_cnt saturates at 2.
  - All comparisons are strict, so equal magnitudes keep the earlier (lower) address.
- Unfilled peak slots read address 0 and magnitude 0.
- Latency: rd_done rises SCAN_LEN+RD_LAT+2 cycles after the start edge (±0, fixed). The bench checks this exactly.
- Reset mid-scan aborts the scan immediately, with no partial results; a fresh rising edge of rd_start is then required.
- rd_start falling mid-scan is ignored; the scan completes.
- No arithmetic overflow: the address counter only ever spans START_ADDR..START_ADDR+SCAN_LEN-1.

Decomposition:
- Shared package holds: the FSM state enum (IDLE, READ, DRAIN, DONE), ADDR_W/DATA_W defaults, and the single-sided bin count constant 2048 that is shared with the writer.
- One sub-module: peak_top2 (3-sample window, candidate test, top-2 insertion). It is fed by valid/addr/data and its peak registers are cleared by a clear strobe.
- The FSM, address generator and latency pipeline stay in ram_rd_ctrl.

Test Plan:
- Single tone: RAM model with bin 100=5000, all others 10, threshold 100, start edge → peak1=(100,5000), peak_cnt=1, peak2=(0,0), rd_done at cycle 2051 (RD_LAT=1).
- Two tones: bin 300=800 and bin 1200=3000, rest 0 → peak1=(1200,3000), peak2=(300,800), peak_cnt=2. Three tones 900/3000/900 at bins 50/500/1500 → peak2=(50,900) because ties keep the earlier bin.
- Threshold and edges: bin 1=9000, bin 2048=9000, bin 700=50, threshold 100 → peak_cnt=0, all peak outputs 0, rd_done=1.
- Plateau: bins 400-402=2000 → exactly one peak at 400.
- Handshake: rd_start held high through DONE → no second scan, with rd_en low after DONE. Drop rd_start and raise it again → full rescan, rd_done cleared during the scan and the same results reproduced. Repeat with RD_LAT=3 → identical peaks, rd_done 2 cycles later.
- Reset mid-scan: rst_n=0 at address 1000 for 1 cycle → next edge has all outputs 0 and IDLE, no further rd_en; a subsequent start edge scans cleanly.
